// File: rtl/id_stage_if.sv
// Fetch/regfile/MEM-facing and ID/EX-facing signals of the decode stage.
// master: the surrounding pipeline; slave: id_stage.
interface id_stage_if;
  logic [31:0] inst_i;
  logic [31:0] pc_i;
  logic        branch_pred_i;
  logic        stall_i;
  logic [4:0]  rs1_addr_o;
  logic [4:0]  rs2_addr_o;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        mem_we_i;
  logic [4:0]  mem_rd_i;
  logic [31:0] mem_data_i;
  logic        pc_stall_o;
  logic        if_stall_o;
  logic        if_flush_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        bp_update_o;
  logic        bp_taken_o;
  logic [31:0] bp_target_o;
  logic [31:0] ex_pc_o;
  logic [31:0] ex_imm_o;
  logic [31:0] ex_rs1_data_o;
  logic [31:0] ex_rs2_data_o;
  logic [4:0]  ex_rd_o;
  logic [6:0]  ex_op_o;
  logic [3:0]  ex_funct_o;
  logic        ex_reg_we_o;
  logic        ex_mem_re_o;
  logic        ex_mem_we_o;

  modport master (
    output inst_i, pc_i, branch_pred_i, stall_i, rs1_data_i, rs2_data_i,
           mem_we_i, mem_rd_i, mem_data_i,
    input  rs1_addr_o, rs2_addr_o, pc_stall_o, if_stall_o, if_flush_o,
           redirect_o, redirect_pc_o, bp_update_o, bp_taken_o, bp_target_o,
           ex_pc_o, ex_imm_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_o, ex_op_o,
           ex_funct_o, ex_reg_we_o, ex_mem_re_o, ex_mem_we_o
  );

  modport slave (
    input  inst_i, pc_i, branch_pred_i, stall_i, rs1_data_i, rs2_data_i,
           mem_we_i, mem_rd_i, mem_data_i,
    output rs1_addr_o, rs2_addr_o, pc_stall_o, if_stall_o, if_flush_o,
           redirect_o, redirect_pc_o, bp_update_o, bp_taken_o, bp_target_o,
           ex_pc_o, ex_imm_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_o, ex_op_o,
           ex_funct_o, ex_reg_we_o, ex_mem_re_o, ex_mem_we_o
  );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: decode, branch/jump resolution in ID, hazard stalls, ID/EX register.
// Define ID_FWD_EN to forward MEM results into ID instead of stalling on MEM writers.
module id_stage #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic     clk,
  input logic     rst,
  id_stage_if.slave bus
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [REG_AW-1:0] rd;
    logic [6:0]        op;
    logic [3:0]        funct;
    logic              reg_we;
    logic              mem_re;
    logic              mem_we;
  } ex_t;

  localparam ex_t EX_BUBBLE = '{pc: RESET_PC, imm: '0, rs1_data: '0, rs2_data: '0,
                                rd: '0, op: '0, funct: '0, reg_we: 1'b0,
                                mem_re: 1'b0, mem_we: 1'b0};

  logic [XLEN-1:0]   inst, pc;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic              valid;
  logic              is_jal, is_jalr, is_branch;
  logic              use1, use2;
  logic [XLEN-1:0]   imm_i, imm_s, imm_b, imm_u, imm_j, imm_sel, link;
  logic [XLEN-1:0]   op1, op2;
  logic              mem_hz, ex_match, hz, br_taken;
  ex_t               ex_q, ex_d, dec;

  logic              pc_stall_c, flush_c, redirect_c, bp_update_c, bp_taken_c;
  logic [XLEN-1:0]   redirect_pc_c, bp_target_c;
  logic [REG_AW-1:0] rs1_addr_c, rs2_addr_c;

  assign inst   = bus.inst_i;
  assign pc     = bus.pc_i;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign rd     = inst[11:7];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];

  assign valid     = (inst != NOP_INST) && (inst != '0);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_branch = (opcode == OPC_BRANCH);

  // Only real sources count; x0 never participates in hazards or forwarding.
  assign use1 = !(opcode == OPC_LUI || opcode == OPC_AUIPC || is_jal) && (rs1 != '0);
  assign use2 = (opcode == OPC_OP || opcode == OPC_STORE || is_branch) && (rs2 != '0);

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign link  = pc + XLEN'(4);

  always_comb begin
    imm_sel = imm_i;
    case (opcode)
      OPC_STORE:          imm_sel = imm_s;
      OPC_BRANCH:         imm_sel = imm_b;
      OPC_LUI, OPC_AUIPC: imm_sel = imm_u;
      OPC_JAL:            imm_sel = imm_j;
      default:            imm_sel = imm_i;
    endcase
  end

`ifdef ID_FWD_EN
  logic fwd1, fwd2;
  assign fwd1   = bus.mem_we_i && (bus.mem_rd_i == rs1) && (rs1 != '0);
  assign fwd2   = bus.mem_we_i && (bus.mem_rd_i == rs2) && (rs2 != '0);
  assign op1    = fwd1 ? bus.mem_data_i : bus.rs1_data_i;
  assign op2    = fwd2 ? bus.mem_data_i : bus.rs2_data_i;
  assign mem_hz = 1'b0;
`else
  logic unused_mem_data;
  assign unused_mem_data = ^bus.mem_data_i;
  assign op1    = bus.rs1_data_i;
  assign op2    = bus.rs2_data_i;
  assign mem_hz = bus.mem_we_i &&
                  ((use1 && bus.mem_rd_i == rs1) || (use2 && bus.mem_rd_i == rs2));
`endif

  assign ex_match = (use1 && ex_q.rd == rs1) || (use2 && ex_q.rd == rs2);
  assign hz = valid && ((ex_q.mem_re && ex_match) ||
                        ((is_branch || is_jalr) && ex_q.reg_we && ex_match) ||
                        mem_hz);

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (op1 == op2);
      3'b001:  br_taken = (op1 != op2);
      3'b100:  br_taken = ($signed(op1) < $signed(op2));
      3'b101:  br_taken = !($signed(op1) < $signed(op2));
      3'b110:  br_taken = (op1 < op2);
      3'b111:  br_taken = !(op1 < op2);
      default: br_taken = 1'b0;
    endcase
  end

  // Stall, redirect and predictor feedback to fetch; all quiet during reset.
  always_comb begin
    pc_stall_c    = 1'b0;
    flush_c       = 1'b0;
    redirect_c    = 1'b0;
    redirect_pc_c = '0;
    bp_update_c   = 1'b0;
    bp_taken_c    = 1'b0;
    bp_target_c   = '0;
    rs1_addr_c    = '0;
    rs2_addr_c    = '0;
    if (!rst) begin
      rs1_addr_c  = rs1;
      rs2_addr_c  = rs2;
      bp_target_c = pc + imm_b;
      if (bus.stall_i || hz) begin
        pc_stall_c = 1'b1;
      end else if (valid) begin
        if (is_branch) begin
          bp_update_c = 1'b1;
          bp_taken_c  = br_taken;
          if (br_taken != bus.branch_pred_i) begin
            redirect_c    = 1'b1;
            flush_c       = 1'b1;
            redirect_pc_c = br_taken ? (pc + imm_b) : link;
          end
        end else if (is_jal && !bus.branch_pred_i) begin
          redirect_c    = 1'b1;
          flush_c       = 1'b1;
          redirect_pc_c = pc + imm_j;
        end else if (is_jalr) begin
          redirect_c    = 1'b1;
          flush_c       = 1'b1;
          redirect_pc_c = (op1 + imm_i) & ~XLEN'(1);
        end
      end
    end
  end

  always_comb begin
    dec.pc       = pc;
    dec.imm      = (is_jal || is_jalr) ? link : imm_sel;
    dec.rs1_data = op1;
    dec.rs2_data = op2;
    dec.rd       = rd;
    dec.op       = opcode;
    dec.funct    = {inst[30], funct3};
    dec.reg_we   = (opcode == OPC_LUI) || (opcode == OPC_AUIPC) || is_jal || is_jalr ||
                   (opcode == OPC_LOAD) || (opcode == OPC_OPIMM) || (opcode == OPC_OP);
    dec.mem_re   = (opcode == OPC_LOAD);
    dec.mem_we   = (opcode == OPC_STORE);
  end

  // Downstream hold freezes the register; hazards and invalid words load a bubble.
  always_comb begin
    ex_d = ex_q;
    if (!bus.stall_i) begin
      ex_d = (valid && !hz) ? dec : EX_BUBBLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_q <= EX_BUBBLE;
    else     ex_q <= ex_d;
  end

  assign bus.rs1_addr_o    = rs1_addr_c;
  assign bus.rs2_addr_o    = rs2_addr_c;
  assign bus.pc_stall_o    = pc_stall_c;
  assign bus.if_stall_o    = pc_stall_c;
  assign bus.if_flush_o    = flush_c;
  assign bus.redirect_o    = redirect_c;
  assign bus.redirect_pc_o = redirect_pc_c;
  assign bus.bp_update_o   = bp_update_c;
  assign bus.bp_taken_o    = bp_taken_c;
  assign bus.bp_target_o   = bp_target_c;
  assign bus.ex_pc_o       = ex_q.pc;
  assign bus.ex_imm_o      = ex_q.imm;
  assign bus.ex_rs1_data_o = ex_q.rs1_data;
  assign bus.ex_rs2_data_o = ex_q.rs2_data;
  assign bus.ex_rd_o       = ex_q.rd;
  assign bus.ex_op_o       = ex_q.op;
  assign bus.ex_funct_o    = ex_q.funct;
  assign bus.ex_reg_we_o   = ex_q.reg_we;
  assign bus.ex_mem_re_o   = ex_q.mem_re;
  assign bus.ex_mem_we_o   = ex_q.mem_we;

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage; honours ID_FWD_EN for the forwarding case.
module tb_id_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_if bus ();

  id_stage #(.NOP_INST(32'h0000_0013), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b010 & {3{op == 7'b0000011}}, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic pred,
                       input logic [31:0] r1, input logic [31:0] r2);
    bus.inst_i        = inst;
    bus.pc_i          = pc;
    bus.branch_pred_i = pred;
    bus.rs1_data_i    = r1;
    bus.rs2_data_i    = r2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    bus.stall_i    = 1'b0;
    bus.mem_we_i   = 1'b0;
    bus.mem_rd_i   = 5'd0;
    bus.mem_data_i = 32'd0;
    drive(enc_i(7'h67, 5'd1, 5'd3, 12'h000), 32'h80, 1'b0, 32'h101, 32'h0);
    #2;
    check("rst_redirect", 32'(bus.redirect_o), 32'd0);
    check("rst_pc_stall", 32'(bus.pc_stall_o), 32'd0);
    check("rst_rs1_addr", 32'(bus.rs1_addr_o), 32'd0);
    check("rst_ex_pc", bus.ex_pc_o, 32'h0);
    check("rst_ex_imm", bus.ex_imm_o, 32'h0);
    check("rst_ex_reg_we", 32'(bus.ex_reg_we_o), 32'd0);

    step();
    rst = 1'b0;
    drive(32'h0000_0013, 32'h4, 1'b0, 32'h0, 32'h0);
    #1;
    check("nop_pc_stall", 32'(bus.pc_stall_o), 32'd0);
    check("nop_redirect", 32'(bus.redirect_o), 32'd0);
    step();
    check("nop_ex_reg_we", 32'(bus.ex_reg_we_o), 32'd0);
    check("nop_ex_pc", bus.ex_pc_o, 32'h0);

    // Load to x0 never stalls its consumer
    drive(enc_i(7'h03, 5'd0, 5'd1, 12'h000), 32'h8, 1'b0, 32'h0, 32'h0);
    step();
    drive(enc_r(5'd6, 5'd0, 5'd0), 32'hC, 1'b0, 32'h0, 32'h0);
    #1;
    check("x0_no_stall", 32'(bus.pc_stall_o), 32'd0);
    step();

    // Load-use
    drive(enc_i(7'h03, 5'd5, 5'd1, 12'h000), 32'h10, 1'b0, 32'h0, 32'h0);
    #1;
    check("lw_rs1_addr", 32'(bus.rs1_addr_o), 32'd1);
    step();
    check("lw_ex_mem_re", 32'(bus.ex_mem_re_o), 32'd1);
    check("lw_ex_rd", 32'(bus.ex_rd_o), 32'd5);
    check("lw_ex_op", 32'(bus.ex_op_o), 32'h03);
    check("lw_ex_pc", bus.ex_pc_o, 32'h10);
    drive(enc_r(5'd6, 5'd5, 5'd1), 32'h14, 1'b0, 32'h55, 32'h11);
    #1;
    check("lu_pc_stall", 32'(bus.pc_stall_o), 32'd1);
    check("lu_if_stall", 32'(bus.if_stall_o), 32'd1);
    check("lu_if_flush", 32'(bus.if_flush_o), 32'd0);
    step();
    check("lu_bubble_we", 32'(bus.ex_reg_we_o), 32'd0);
    check("lu_bubble_re", 32'(bus.ex_mem_re_o), 32'd0);
    check("lu_bubble_pc", bus.ex_pc_o, 32'h0);
    check("lu_released", 32'(bus.pc_stall_o), 32'd0);
    step();
    check("add_ex_we", 32'(bus.ex_reg_we_o), 32'd1);
    check("add_ex_rd", 32'(bus.ex_rd_o), 32'd6);
    check("add_ex_pc", bus.ex_pc_o, 32'h14);
    check("add_ex_rs1", bus.ex_rs1_data_o, 32'h55);
    check("add_ex_rs2", bus.ex_rs2_data_o, 32'h11);
    check("add_ex_funct", 32'(bus.ex_funct_o), 32'h0);

    // Store with negative offset
    drive(enc_s(5'd1, 5'd2, 12'hFFC), 32'h18, 1'b0, 32'h100, 32'hAB);
    #1;
    check("sw_no_stall", 32'(bus.pc_stall_o), 32'd0);
    step();
    check("sw_ex_mem_we", 32'(bus.ex_mem_we_o), 32'd1);
    check("sw_ex_imm", bus.ex_imm_o, 32'hFFFF_FFFC);
    check("sw_ex_we", 32'(bus.ex_reg_we_o), 32'd0);
    check("sw_ex_rs2", bus.ex_rs2_data_o, 32'hAB);

    // BEQ mispredicted not-taken
    drive(enc_b(3'b000, 5'd1, 5'd2, 13'h0010), 32'h40, 1'b0, 32'd7, 32'd7);
    #1;
    check("beq_redirect", 32'(bus.redirect_o), 32'd1);
    check("beq_redirect_pc", bus.redirect_pc_o, 32'h50);
    check("beq_flush", 32'(bus.if_flush_o), 32'd1);
    check("beq_bp_update", 32'(bus.bp_update_o), 32'd1);
    check("beq_bp_taken", 32'(bus.bp_taken_o), 32'd1);
    check("beq_bp_target", bus.bp_target_o, 32'h50);
    check("beq_no_stall", 32'(bus.pc_stall_o), 32'd0);
    step();
    check("beq_ex_pc", bus.ex_pc_o, 32'h40);
    check("beq_ex_imm", bus.ex_imm_o, 32'h10);

    drive(enc_b(3'b000, 5'd1, 5'd2, 13'h0010), 32'h40, 1'b1, 32'd7, 32'd7);
    #1;
    check("beqok_redirect", 32'(bus.redirect_o), 32'd0);
    check("beqok_flush", 32'(bus.if_flush_o), 32'd0);
    check("beqok_bp_update", 32'(bus.bp_update_o), 32'd1);
    step();

    drive(enc_b(3'b000, 5'd1, 5'd2, 13'h0010), 32'h40, 1'b1, 32'd7, 32'd8);
    #1;
    check("beqnt_redirect", 32'(bus.redirect_o), 32'd1);
    check("beqnt_redirect_pc", bus.redirect_pc_o, 32'h44);
    check("beqnt_bp_taken", 32'(bus.bp_taken_o), 32'd0);
    step();

    drive(enc_b(3'b100, 5'd1, 5'd2, 13'h0010), 32'h40, 1'b0, 32'hFFFF_FFFF, 32'd1);
    #1;
    check("blt_redirect_pc", bus.redirect_pc_o, 32'h50);
    check("blt_bp_taken", 32'(bus.bp_taken_o), 32'd1);
    step();

    drive(enc_b(3'b110, 5'd1, 5'd2, 13'h0010), 32'h40, 1'b0, 32'hFFFF_FFFF, 32'd1);
    #1;
    check("bltu_redirect", 32'(bus.redirect_o), 32'd0);
    check("bltu_bp_taken", 32'(bus.bp_taken_o), 32'd0);
    check("bltu_bp_update", 32'(bus.bp_update_o), 32'd1);
    step();

    drive(enc_b(3'b001, 5'd1, 5'd2, 13'h1FF8), 32'h40, 1'b0, 32'd1, 32'd0);
    #1;
    check("bne_back_pc", bus.redirect_pc_o, 32'h38);
    step();

    drive(enc_b(3'b001, 5'd1, 5'd2, 13'h0010), 32'hFFFF_FFF8, 1'b0, 32'd1, 32'd0);
    #1;
    check("bne_wrap_pc", bus.redirect_pc_o, 32'h8);
    check("bne_wrap_target", bus.bp_target_o, 32'h8);
    step();

    // JALR clears bit 0 of the target and links pc+4
    drive(enc_i(7'h67, 5'd1, 5'd3, 12'h000), 32'h80, 1'b0, 32'h101, 32'h0);
    #1;
    check("jalr_redirect", 32'(bus.redirect_o), 32'd1);
    check("jalr_redirect_pc", bus.redirect_pc_o, 32'h100);
    check("jalr_flush", 32'(bus.if_flush_o), 32'd1);
    check("jalr_bp_update", 32'(bus.bp_update_o), 32'd0);
    step();
    check("jalr_ex_imm", bus.ex_imm_o, 32'h84);
    check("jalr_ex_we", 32'(bus.ex_reg_we_o), 32'd1);
    check("jalr_ex_rd", 32'(bus.ex_rd_o), 32'd1);
    check("jalr_ex_op", 32'(bus.ex_op_o), 32'h67);

    // ALU consumer of an EX-stage ALU result does not stall; branch consumer does
    drive(enc_r(5'd7, 5'd1, 5'd2), 32'h84, 1'b0, 32'h0, 32'h0);
    #1;
    check("alu_dep_no_stall", 32'(bus.pc_stall_o), 32'd0);
    step();
    drive(enc_b(3'b000, 5'd7, 5'd0, 13'h0008), 32'h88, 1'b0, 32'd0, 32'd0);
    #1;
    check("brhz_pc_stall", 32'(bus.pc_stall_o), 32'd1);
    check("brhz_redirect", 32'(bus.redirect_o), 32'd0);
    check("brhz_bp_update", 32'(bus.bp_update_o), 32'd0);
    step();
    check("brhz_bubble_we", 32'(bus.ex_reg_we_o), 32'd0);
    check("brhz_bubble_pc", bus.ex_pc_o, 32'h0);
    check("brhz_resolve", 32'(bus.redirect_o), 32'd1);
    check("brhz_resolve_pc", bus.redirect_pc_o, 32'h90);
    step();
    check("brhz_ex_pc", bus.ex_pc_o, 32'h88);

    // JAL
    drive(enc_j(5'd1, 21'h00020), 32'h100, 1'b0, 32'h0, 32'h0);
    #1;
    check("jal_redirect_pc", bus.redirect_pc_o, 32'h120);
    check("jal_bp_update", 32'(bus.bp_update_o), 32'd0);
    bus.branch_pred_i = 1'b1;
    #1;
    check("jal_pred_redirect", 32'(bus.redirect_o), 32'd0);
    step();
    check("jal_ex_imm", bus.ex_imm_o, 32'h104);
    check("jal_ex_op", 32'(bus.ex_op_o), 32'h6F);

    // stall_i beats a simultaneous hazard: the register holds instead of bubbling
    bus.stall_i = 1'b1;
    drive(enc_b(3'b000, 5'd1, 5'd2, 13'h0010), 32'h40, 1'b0, 32'd7, 32'd7);
    #1;
    check("st_pc_stall", 32'(bus.pc_stall_o), 32'd1);
    check("st_if_stall", 32'(bus.if_stall_o), 32'd1);
    check("st_redirect", 32'(bus.redirect_o), 32'd0);
    check("st_flush", 32'(bus.if_flush_o), 32'd0);
    check("st_bp_update", 32'(bus.bp_update_o), 32'd0);
    step();
    check("st_hold_pc", bus.ex_pc_o, 32'h100);
    check("st_hold_imm", bus.ex_imm_o, 32'h104);
    bus.stall_i = 1'b0;
    #1;
    check("st_then_hz", 32'(bus.pc_stall_o), 32'd1);
    step();
    check("st_then_bubble", bus.ex_pc_o, 32'h0);

    // MEM-stage writer feeding a branch
    bus.mem_we_i   = 1'b1;
    bus.mem_rd_i   = 5'd4;
    bus.mem_data_i = 32'd1;
    drive(enc_b(3'b001, 5'd4, 5'd0, 13'h0008), 32'h200, 1'b0, 32'd0, 32'd0);
    #1;
`ifdef ID_FWD_EN
    check("fwd_no_stall", 32'(bus.pc_stall_o), 32'd0);
    check("fwd_redirect", 32'(bus.redirect_o), 32'd1);
    check("fwd_redirect_pc", bus.redirect_pc_o, 32'h208);
    check("fwd_bp_taken", 32'(bus.bp_taken_o), 32'd1);
    step();
    check("fwd_ex_rs1", bus.ex_rs1_data_o, 32'd1);
    check("fwd_ex_pc", bus.ex_pc_o, 32'h200);
    bus.mem_we_i = 1'b0;
`else
    check("nofwd_stall", 32'(bus.pc_stall_o), 32'd1);
    check("nofwd_redirect", 32'(bus.redirect_o), 32'd0);
    check("nofwd_bp_update", 32'(bus.bp_update_o), 32'd0);
    step();
    check("nofwd_bubble_pc", bus.ex_pc_o, 32'h0);
    bus.mem_we_i   = 1'b0;
    bus.rs1_data_i = 32'd1;
    #1;
    check("nofwd_redirect2", 32'(bus.redirect_o), 32'd1);
    check("nofwd_redirect_pc", bus.redirect_pc_o, 32'h208);
    check("nofwd_bp_taken", 32'(bus.bp_taken_o), 32'd1);
    step();
    check("nofwd_ex_rs1", bus.ex_rs1_data_o, 32'd1);
    check("nofwd_ex_pc", bus.ex_pc_o, 32'h200);
`endif

    // Reset during a load-use stall leaves no stall behind
    drive(enc_i(7'h03, 5'd5, 5'd1, 12'h000), 32'h300, 1'b0, 32'h0, 32'h0);
    step();
    drive(enc_r(5'd6, 5'd5, 5'd1), 32'h304, 1'b0, 32'h0, 32'h0);
    #1;
    check("rstst_stall", 32'(bus.pc_stall_o), 32'd1);
    rst = 1'b1;
    #1;
    check("rstst_stall_clr", 32'(bus.pc_stall_o), 32'd0);
    check("rstst_ex_mem_re", 32'(bus.ex_mem_re_o), 32'd0);
    check("rstst_ex_pc", bus.ex_pc_o, 32'h0);
    step();
    rst = 1'b0;
    #1;
    check("rstst_after", 32'(bus.pc_stall_o), 32'd0);
    step();
    check("rstst_ex_pc2", bus.ex_pc_o, 32'h304);
    check("rstst_ex_we", 32'(bus.ex_reg_we_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
